// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl shared types and constants.
// FSM state encoding and default access length.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        WR_HOLD,
        DONE
    } state_e;

    localparam int DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/sram_ctrl.sv
// Asynchronous 32-bit SRAM controller for a stalling CPU data bus.
// One FSM plus one down-counter; all SRAM strobes are registered.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_address,
    input  logic [3:0]  bus_byteenable,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [31:0] bus_wrdata,
    output logic [31:0] bus_rddata,
    output logic        bus_stall,
    output logic [19:0] sram_addr,
    output logic [31:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [31:0] sram_dq_i,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [3:0]  sram_be_n
);

    localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);

    state_e      state;
    logic [3:0]  cnt;
    logic [19:0] addr_q;
    logic [31:0] data_q;
    logic        unused_addr_bits;

    // Only word address bits [21:2] reach the SRAM.
    assign unused_addr_bits = ^{bus_address[31:22], bus_address[1:0]};

    assign sram_addr = addr_q;
    assign sram_dq_o = data_q;

    // Stall is released only in DONE so the CPU advances on that edge.
    assign bus_stall = (bus_read | bus_write) & (state != DONE);

    // Access sequencer: state, counter, latched request and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            bus_rddata <= '0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_be_n  <= 4'hF;
            sram_dq_oe <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus_write) begin
                        addr_q     <= bus_address[21:2];
                        data_q     <= bus_wrdata;
                        cnt        <= RELOAD;
                        sram_ce_n  <= 1'b0;
                        sram_we_n  <= 1'b0;
                        sram_be_n  <= ~bus_byteenable;
                        sram_dq_oe <= 1'b1;
                        state      <= WRITE;
                    end else if (bus_read) begin
                        addr_q    <= bus_address[21:2];
                        cnt       <= RELOAD;
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                        sram_be_n <= 4'h0;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (cnt == 4'd0) begin
                        bus_rddata <= sram_dq_i;
                        sram_ce_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_be_n  <= 4'hF;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WRITE: begin
                    if (cnt == 4'd0) begin
                        sram_we_n <= 1'b1;
                        state     <= WR_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_HOLD: begin
                    sram_ce_n  <= 1'b1;
                    sram_be_n  <= 4'hF;
                    sram_dq_oe <= 1'b0;
                    state      <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl.
// Main instance uses WAIT_CYCLES=2; two more cover 1 and 5.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_address;
    logic [3:0]  bus_byteenable;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_wrdata;
    logic [31:0] bus_rddata;
    logic        bus_stall;
    logic [19:0] sram_addr;
    logic [31:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [31:0] sram_dq_i;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;

    logic        a1_read, a5_read;
    logic [31:0] a1_rddata, a5_rddata, a1_dq_o, a5_dq_o;
    logic        a1_stall, a5_stall, a1_dq_oe, a5_dq_oe;
    logic [19:0] a1_addr, a5_addr;
    logic        a1_ce_n, a1_oe_n, a1_we_n, a5_ce_n, a5_oe_n, a5_we_n;
    logic [3:0]  a1_be_n, a5_be_n;

    logic [31:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .bus_address(bus_address), .bus_byteenable(bus_byteenable),
        .bus_read(bus_read), .bus_write(bus_write),
        .bus_wrdata(bus_wrdata), .bus_rddata(bus_rddata),
        .bus_stall(bus_stall), .sram_addr(sram_addr),
        .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_be_n(sram_be_n)
    );

    sram_ctrl #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst),
        .bus_address(32'h8000_0100), .bus_byteenable(4'hF),
        .bus_read(a1_read), .bus_write(1'b0),
        .bus_wrdata(32'h0), .bus_rddata(a1_rddata),
        .bus_stall(a1_stall), .sram_addr(a1_addr),
        .sram_dq_o(a1_dq_o), .sram_dq_oe(a1_dq_oe),
        .sram_dq_i(32'h5A5A_0001), .sram_ce_n(a1_ce_n),
        .sram_oe_n(a1_oe_n), .sram_we_n(a1_we_n),
        .sram_be_n(a1_be_n)
    );

    sram_ctrl #(.WAIT_CYCLES(5)) u_w5 (
        .clk(clk), .rst(rst),
        .bus_address(32'h8000_0100), .bus_byteenable(4'hF),
        .bus_read(a5_read), .bus_write(1'b0),
        .bus_wrdata(32'h0), .bus_rddata(a5_rddata),
        .bus_stall(a5_stall), .sram_addr(a5_addr),
        .sram_dq_o(a5_dq_o), .sram_dq_oe(a5_dq_oe),
        .sram_dq_i(32'h5A5A_0005), .sram_ce_n(a5_ce_n),
        .sram_oe_n(a5_oe_n), .sram_we_n(a5_we_n),
        .sram_be_n(a5_be_n)
    );

    // SRAM model: async read, byte-lane write while WE_n is low.
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ?
                       mem[sram_addr[7:0]] : 32'hDEAD_0000;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            for (int i = 0; i < 4; i++)
                if (!sram_be_n[i])
                    mem[sram_addr[7:0]][8*i +: 8] <= sram_dq_o[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, hold it while stalled; returns in the DONE cycle.
    task automatic access(input logic rd, input logic wr,
                          input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d,
                          output int ns, output int nwe, output int noe,
                          output int nhold, output logic [3:0] be_s,
                          output logic [19:0] addr_s,
                          output logic [31:0] dq_s);
        bus_read       = rd;
        bus_write      = wr;
        bus_address    = a;
        bus_byteenable = be;
        bus_wrdata     = d;
        ns = 0; nwe = 0; noe = 0; nhold = 0;
        be_s = 4'hF; addr_s = '0; dq_s = '0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!sram_we_n) begin
                nwe++;
                be_s = sram_be_n;
                dq_s = sram_dq_o;
            end
            if (!sram_oe_n) begin
                noe++;
                be_s = sram_be_n;
            end
            if (!sram_ce_n && sram_we_n && sram_dq_oe
                && sram_dq_o == d)
                nhold++;
            if (!sram_ce_n)
                addr_s = sram_addr;
            if (!bus_stall)
                break;
            ns++;
            tick();
        end
        chk("stall_drop", {31'b0, bus_stall}, 32'd0);
        bus_read  = 1'b0;
        bus_write = 1'b0;
    endtask

    int ns, nwe, noe, nhold, n1, n5;
    logic [3:0]  be_s;
    logic [19:0] addr_s;
    logic [31:0] dq_s;

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = 32'h0101_0101 * i;
        mem[8'h04] = 32'h1234_5678;
        mem[8'h08] = 32'h1122_3344;
        rst = 1'b1;
        bus_read = 1'b0; bus_write = 1'b0;
        bus_address = '0; bus_byteenable = '0; bus_wrdata = '0;
        a1_read = 1'b0; a5_read = 1'b0;
        repeat (3) tick();

        chk("rst_rddata", bus_rddata, 32'h0);
        chk("rst_strobes", {28'b0, sram_ce_n, sram_oe_n, sram_we_n,
            sram_dq_oe}, 32'hE);
        chk("rst_be_n", {28'b0, sram_be_n}, 32'hF);
        chk("rst_addr", {12'b0, sram_addr}, 32'h0);
        chk("rst_dq_o", sram_dq_o, 32'h0);
        chk("rst_stall", {31'b0, bus_stall}, 32'h0);
        rst = 1'b0;
        tick();

        // Read 0x80000010 -> word 4
        access(1'b1, 1'b0, 32'h8000_0010, 4'h0, 32'h0,
               ns, nwe, noe, nhold, be_s, addr_s, dq_s);
        chk("rd_stall", ns, 3);
        chk("rd_oe_cycles", noe, 2);
        chk("rd_addr", {12'b0, addr_s}, 32'h4);
        chk("rd_be_n", {28'b0, be_s}, 32'h0);
        chk("rd_data", bus_rddata, 32'h1234_5678);
        tick();

        // Partial write, lanes 0 and 2
        access(1'b0, 1'b1, 32'h8000_0020, 4'b0101, 32'hAABB_CCDD,
               ns, nwe, noe, nhold, be_s, addr_s, dq_s);
        chk("wr_stall", ns, 4);
        chk("wr_we_cycles", nwe, 2);
        chk("wr_hold", nhold, 1);
        chk("wr_be_n", {28'b0, be_s}, 32'hA);
        chk("wr_addr", {12'b0, addr_s}, 32'h8);
        chk("wr_dq", dq_s, 32'hAABB_CCDD);
        chk("wr_mem", mem[8'h08], 32'h11BB_33DD);
        chk("rd_keep", bus_rddata, 32'h1234_5678);
        tick();

        // Write then immediate read of the same word
        access(1'b0, 1'b1, 32'h8000_0040, 4'hF, 32'hCAFE_F00D,
               ns, nwe, noe, nhold, be_s, addr_s, dq_s);
        chk("wr2_stall", ns, 4);
        tick();
        chk("b2b_idle", 32'(dut.state), 32'(IDLE));
        access(1'b1, 1'b0, 32'h8000_0040, 4'h0, 32'h0,
               ns, nwe, noe, nhold, be_s, addr_s, dq_s);
        chk("b2b_stall", ns, 3);
        chk("b2b_data", bus_rddata, 32'hCAFE_F00D);
        tick();

        // Read and write together behave as a write
        access(1'b1, 1'b1, 32'h8000_0030, 4'hF, 32'h0BAD_BEEF,
               ns, nwe, noe, nhold, be_s, addr_s, dq_s);
        chk("rw_no_oe", noe, 0);
        chk("rw_we", nwe, 2);
        chk("rw_stall", ns, 4);
        chk("rw_mem", mem[8'h0C], 32'h0BAD_BEEF);
        tick();

        // Reset during the second WRITE cycle
        bus_write = 1'b1;
        bus_address = 32'h8000_0050;
        bus_byteenable = 4'hF;
        bus_wrdata = 32'h5555_AAAA;
        tick();
        tick();
        chk("pre_rst_we", {31'b0, sram_we_n}, 32'h0);
        rst = 1'b1;
        tick();
        chk("abort_we_n", {31'b0, sram_we_n}, 32'h1);
        chk("abort_dq_oe", {31'b0, sram_dq_oe}, 32'h0);
        chk("abort_state", 32'(dut.state), 32'(IDLE));
        chk("abort_stall", {31'b0, bus_stall}, 32'h1);
        bus_write = 1'b0;
        rst = 1'b0;
        tick();

        // Flush after one READ cycle at WAIT_CYCLES 1 and 5
        a1_read = 1'b1;
        a5_read = 1'b1;
        tick();
        a1_read = 1'b0;
        a5_read = 1'b0;
        n1 = 0;
        n5 = 0;
        for (int i = 0; i < 20; i++) begin
            if (!a1_oe_n) n1++;
            if (!a5_oe_n) n5++;
            tick();
        end
        chk("w1_oe_cycles", n1, 1);
        chk("w5_oe_cycles", n5, 5);
        chk("w1_idle", 32'(u_w1.state), 32'(IDLE));
        chk("w5_idle", 32'(u_w5.state), 32'(IDLE));
        chk("w1_data", a1_rddata, 32'h5A5A_0001);
        chk("w5_data", a5_rddata, 32'h5A5A_0005);
        chk("w5_stall", {31'b0, a5_stall}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of cycles OE_n/WE_n are held low per access (legal range 1..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 bus_address  input  32  CPU data-bus byte address; only bits [21:2] used.
REQ-005 bus_byteenable  input  4  byte lanes for write, bit i = bits [8i+7:8i].
REQ-006 bus_read  input  1  read request, held by CPU until stall drops.
REQ-007 bus_write  input  1  write request, held by CPU until stall drops.
REQ-008 bus_wrdata  input  32  write data.
REQ-009 bus_rddata  output  32  registered read data.
REQ-010 bus_stall  output  1  CPU must hold the request while high.
REQ-011 sram_addr  output  20  SRAM word address.
REQ-012 sram_dq_o  output  32  data to SRAM; sram_dq_oe output 1 is the tristate enable, with the pad kept outside this block.
REQ-013 sram_dq_i  input  32  data from SRAM.
REQ-014 sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low strobes.
REQ-015 sram_be_n  output  4  active-low byte enables; [1:0] go to the low chip and [3:2] to the high chip.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, WR_HOLD, DONE.
REQ-017 IDLE: bus_write, including when bus_read is also high, SHALL latch address, byteenable and wrdata and go to WRITE; bus_read alone SHALL latch the address and go to READ; otherwise stay in IDLE.
REQ-018 READ: SHALL drive ce_n=0, oe_n=0 and be_n=0000 for WAIT_CYCLES cycles; in the last cycle it SHALL capture sram_dq_i into bus_rddata and go to DONE.
REQ-019 WRITE: SHALL drive ce_n=0, we_n=0, be_n=~latched byteenable and dq_oe=1 for WAIT_CYCLES cycles, then go to WR_HOLD.
REQ-020 WR_HOLD: SHALL drive we_n=1 for 1 cycle with dq_oe=1 and the data still driven as hold time, then go to DONE.
REQ-021 DONE: SHALL go to IDLE unconditionally after 1 cycle.
REQ-022 bus_stall SHALL be combinational and equal (bus_read|bus_write) & (state!=DONE); it is low in DONE, so the CPU advances at that edge.
REQ-023 Read stall SHALL last 1+WAIT_CYCLES cycles; write stall SHALL last 2+WAIT_CYCLES cycles.
REQ-024 A new request present in the cycle after DONE SHALL be accepted from IDLE with no extra bubble.
REQ-025 If the request drops mid-access (flush), the block SHALL complete the SRAM cycle and return to IDLE; a write SHALL never be truncated.
REQ-026 sram_addr and sram_dq_o SHALL come from latched registers and SHALL be stable throughout every access.
REQ-027 bus_rddata SHALL hold its value until the next read completes.
REQ-028 A single down-counter, width 4, SHALL time both READ and WRITE; it reloads to WAIT_CYCLES-1 on entry.

Reset
REQ-029 When rst=1 at an edge: state=IDLE, counter=0, bus_rddata=0, ce_n=oe_n=we_n=1, be_n=1111, dq_oe=0, latched address and data=0.
REQ-030 rst SHALL abort any access in progress, including mid-write; bus_stall SHALL follow REQ-022 with state=IDLE.

Structure
REQ-031 Package sram_ctrl_pkg SHALL hold the state enum and the default WAIT_CYCLES constant.
REQ-032 The block SHALL have no sub-module; the FSM and counter are one module, and the tristate pad belongs to the top level.

Verification
REQ-033 Read of 0x80000010 with the SRAM model word = 0x12345678 and WAIT=2 -> stall high 3 cycles, sram_addr=0x00004, bus_rddata=0x12345678 in the DONE cycle.
REQ-034 Write 0xAABBCCDD with byteenable=0101 to 0x80000020 -> we_n low 2 cycles, be_n=1010, stall high 4 cycles, SRAM word afterwards = 0x??BB??DD with the ?? lanes unchanged.
REQ-035 Write immediately followed by a read of the same address -> no idle bubble after DONE, read returns the written value.
REQ-036 Read and write both asserted -> treated as a write; no oe_n pulse occurs.
REQ-037 rst raised in the 2nd WRITE cycle -> next cycle we_n=1, dq_oe=0, state IDLE.
REQ-038 Request dropped after 1 READ cycle -> oe_n remains low for the full WAIT_CYCLES, then IDLE; run with WAIT_CYCLES=1 and 5.
